hilo_div_unit: RTL and testbench
================================

// Module: hilo_div_unit
// PURPOSE
//  Iterative 32-bit DIV/DIVU engine in the EX stage. Result goes to the HI/LO
//  write path: LO = quotient, HI = remainder.
//  Drives the EX-stage HI/LO info bus, which feeds HI/LO forwarding.
//  While a division runs, that bus reports "HI/LO being written, value not
//  yet valid", so readers stall. Also raises the pipeline stall request.
// PARAMETERS
//  DATA_W   32  operand/result width (only 32 is supported)
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk           in   1       core clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  flush         in   1       pipeline flush (exception/eret); aborts the division
//  div_start     in   1       EX holds a DIV/DIVU; sampled only in IDLE
//  div_signed    in   1       1 = DIV (signed), 0 = DIVU
//  dividend      in   32      rs value, captured on accepted start
//  divisor       in   32      rt value, captured on accepted start
//  busy          out  1       engine in CALC or DONE
//  done          out  1       one-cycle pulse; result is valid this cycle
//  stall_req     out  1       = div_start & ~done (holds EX/IF/ID)
//  info_hilo_ex  out  68      {w_en_hi, w_en_lo, data_hi[31:0], data_lo[31:0], hi_valid, lo_valid}
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, counter=0, internal regs=0.
//    Next cycle busy=0, done=0, info_hilo_ex=0.
//    Reset mid-division discards the division; no done pulse.
//  - States IDLE -> CALC -> DONE -> IDLE.
//    IDLE: if div_start & ~flush at edge T, capture operands; go to CALC.
//      If divisor==0, go straight to DONE (div-by-zero path below).
//    CALC: one restoring shift-subtract step per cycle, counter 0..31.
//      After step 31 go to DONE.
//    DONE: lasts exactly one cycle (done=1), then IDLE.
//      If div_start is still high in that IDLE cycle, a new division starts
//      (the pipeline deasserts it once EX advances).
//  - Latency: accept at edge T. Steps occupy cycles T+1..T+32. done=1 in cycle T+33.
//    Div-by-zero: done=1 in cycle T+1.
//  - Signed: divide magnitudes.
//    Quotient is negated when the operand signs differ.
//    Remainder takes the sign of the dividend.
//    0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
//  - Divide by zero (both modes): LO=0xFFFF_FFFF, HI=dividend unchanged.
//  - info_hilo_ex:
//    * IDLE with no accepted start: all zero.
//    * CALC, and the accept cycle: w_en_hi=w_en_lo=1, data=0, hi_valid=lo_valid=0.
//    * DONE: w_en=1, data_hi=remainder, data_lo=quotient, valid=1.
//  - Start while busy is ignored; operands are not re-captured.
//  - flush in any state: next cycle is IDLE, busy=0, no done.
//    flush overrides div_start in the same cycle.
//    flush coincident with done: done still shows this cycle; the pipeline
//    discards the result.
//  - stall_req is combinational. It is 0 in the done cycle, so EX advances
//    with the result.
// STRUCTURE
//  - Shared header defines_cpu.vh holds:
//    * data_bus, info_hilo_bus (67:0), zero_32, true_v/false_v
//    * state encodings DIV_IDLE/DIV_CALC/DIV_DONE
//  - Sub-module div_iter_step (combinational):
//    * inputs: {rem, quo} partial pair and |divisor|
//    * output: next pair after one shift + trial subtract
//    * instantiated once in the sequential datapath.
//  - Sign pre-fix (abs) and post-fix (negate) logic stays in this module.
// TESTING
//  1. DIVU 100/7, start held:
//     busy rises T+1; done only at T+33 with LO=14, HI=2; stall_req low at T+33.
//  2. DIV -7/2 (0xFFFF_FFF9 / 2): LO=0xFFFF_FFFD, HI=0xFFFF_FFFF at T+33.
//  3. DIV 0x8000_0000 / 0xFFFF_FFFF:
//     LO=0x8000_0000, HI=0; DIVU of the same operands: LO=0, HI=0x8000_0000.
//  4. DIVU 0x1234 / 0: done at T+1, LO=0xFFFF_FFFF, HI=0x1234, valid=1.
//  5. Interrupts:
//     * flush at step 10: busy=0 next cycle, no done, info_hilo_ex=0.
//     * fresh start then completes correctly.
//     * Repeat with rst instead of flush.
//  6. Start while busy with new operands: ignored, first result unaffected.
//     During CALC, hi_valid=lo_valid=0 and w_en=1 every cycle.

Source files
------------

// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO divide engine: bus layouts,
// FSM state encodings and the operand magnitude helper.
package hilo_div_unit_pkg;

    localparam int HILO_DATA_W = 32;

    typedef logic [HILO_DATA_W-1:0] data_bus_t;

    localparam data_bus_t ZERO_32 = '0;
    localparam logic      TRUE_V  = 1'b1;
    localparam logic      FALSE_V = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Same bit order as the 68-bit EX-stage HI/LO info bus.
    typedef struct packed {
        logic      w_en_hi;
        logic      w_en_lo;
        data_bus_t data_hi;
        data_bus_t data_lo;
        logic      hi_valid;
        logic      lo_valid;
    } info_hilo_bus_t;

    function automatic data_bus_t abs_val(input data_bus_t v, input logic is_signed);
        return (is_signed && v[HILO_DATA_W-1]) ? (ZERO_32 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit_iter_step.sv
// One restoring shift-subtract step: shifts the {rem, quo} pair left by one
// and keeps the trial subtraction only when it does not borrow.
module div_iter_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] w_shifted;
    logic [W:0] w_diff;

    // One extra bit so the shifted remainder cannot overflow before the compare.
    assign w_shifted = {i_rem, i_quo[W-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    always_comb begin
        if (w_diff[W]) begin
            o_rem = w_shifted[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b0};
        end else begin
            o_rem = w_diff[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative 32-bit DIV/DIVU engine in EX: LO = quotient, HI = remainder,
// reported on the EX HI/LO info bus so forwarding readers stall until done.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                div_start,
    input  logic                div_signed,
    input  logic [DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]   divisor,
    output logic                busy,
    output logic                done,
    output logic                stall_req,
    output logic [2*DATA_W+3:0] info_hilo_ex
);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    data_bus_t        r_rem;
    data_bus_t        r_quo;
    data_bus_t        r_divisor;
    logic             r_neg_quo;
    logic             r_neg_rem;

    data_bus_t        w_step_rem;
    data_bus_t        w_step_quo;
    logic             w_accept;
    logic             w_div_zero;
    logic             w_last_step;
    info_hilo_bus_t   w_info;

    assign w_accept    = (r_state == DIV_IDLE) && div_start && !flush && !rst;
    assign w_div_zero  = (divisor == ZERO_32);
    assign w_last_step = (r_cnt == CNT_W'(DATA_W - 1));

    div_iter_step #(
        .W(DATA_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: if (div_start) w_state_next = w_div_zero ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (w_last_step) w_state_next = DIV_DONE;
                DIV_DONE: w_state_next = DIV_IDLE;
                default:  w_state_next = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_rem     <= ZERO_32;
            r_quo     <= ZERO_32;
            r_divisor <= ZERO_32;
            r_neg_quo <= FALSE_V;
            r_neg_rem <= FALSE_V;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt     <= '0;
                r_divisor <= abs_val(divisor, div_signed);
                if (w_div_zero) begin
                    // Divide by zero bypasses CALC: LO all ones, HI the raw dividend.
                    r_rem     <= dividend;
                    r_quo     <= '1;
                    r_neg_quo <= FALSE_V;
                    r_neg_rem <= FALSE_V;
                end else begin
                    r_rem     <= ZERO_32;
                    r_quo     <= abs_val(dividend, div_signed);
                    r_neg_quo <= div_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                    r_neg_rem <= div_signed && dividend[DATA_W-1];
                end
            end else if (r_state == DIV_CALC && !flush) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_info = '0;
        if (r_state == DIV_DONE) begin
            w_info.w_en_hi  = TRUE_V;
            w_info.w_en_lo  = TRUE_V;
            w_info.data_hi  = r_neg_rem ? (ZERO_32 - r_rem) : r_rem;
            w_info.data_lo  = r_neg_quo ? (ZERO_32 - r_quo) : r_quo;
            w_info.hi_valid = TRUE_V;
            w_info.lo_valid = TRUE_V;
        end else if (r_state == DIV_CALC || w_accept) begin
            w_info.w_en_hi = TRUE_V;
            w_info.w_en_lo = TRUE_V;
        end
    end

    assign busy         = (r_state != DIV_IDLE);
    assign done         = (r_state == DIV_DONE);
    assign stall_req    = div_start && !done;
    assign info_hilo_ex = w_info;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: a cycle-count model predicts every output
// each cycle, and literal quotient/remainder/latency values pin each division.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [67:0] info_hilo_ex;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: division in flight, cycles since accept, cycle count to done, {hi,lo}.
    bit          m_act = 1'b0;
    int          m_k   = 0;
    int          m_len = 0;
    logic [63:0] m_exp = '0;

    hilo_div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .stall_req    (stall_req),
        .info_hilo_ex (info_hilo_ex)
    );

    always #5 clk = ~clk;

    // Returns {hi, lo} from plain 64-bit arithmetic; no overflow at 0x8000_0000 / -1.
    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            la = $signed(a);
            lb = $signed(b);
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst || flush) begin
            m_act <= 1'b0;
        end else if (m_act) begin
            if (m_k == m_len) m_act <= 1'b0;
            else              m_k   <= m_k + 1;
        end else if (div_start) begin
            m_act <= 1'b1;
            m_k   <= 1;
            m_len <= (divisor == 32'd0) ? 1 : 33;
            m_exp <= model_div(div_signed, dividend, divisor);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_done;
            logic [67:0] e_info;
            e_done = m_act && (m_k == m_len);
            if (e_done)
                e_info = {2'b11, m_exp, 2'b11};
            else if (m_act || (div_start && !flush && !rst))
                e_info = {2'b11, 64'd0, 2'b00};
            else
                e_info = '0;
            chk("cyc_busy", busy, m_act);
            chk("cyc_done", done, e_done);
            chk("cyc_stall", stall_req, div_start && !e_done);
            chk("cyc_info", info_hilo_ex, e_info);
        end
    end

    task automatic run_div(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat,
                           input bit perturb);
        int lat;
        bit seen;
        @(posedge clk); #1;
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({nm, "_busy_rise"}, busy, 1'b1);
            if (done) begin
                seen = 1'b1;
                chk({nm, "_latency"}, lat, exp_lat);
                chk({nm, "_lo"}, info_hilo_ex[33:2], exp_lo);
                chk({nm, "_hi"}, info_hilo_ex[65:34], exp_hi);
                chk({nm, "_valid"}, {info_hilo_ex[67:66], info_hilo_ex[1:0]}, 4'hF);
                chk({nm, "_stall_done"}, stall_req, 1'b0);
                $display("div %s sgn=%0b a=%h b=%h -> lo=%h hi=%h latency=%0d",
                         nm, sgn, a, b, info_hilo_ex[33:2], info_hilo_ex[65:34], lat);
            end else begin
                chk({nm, "_calc_flags"}, {info_hilo_ex[67:66], info_hilo_ex[1:0]}, 4'b1100);
                if (perturb && lat == 5) begin
                    #1;
                    dividend = 32'd9;
                    divisor  = 32'd3;
                end
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 1'b0, 1'b1);
        @(posedge clk); #1;
        div_start = 1'b0;
    endtask

    // abort_kind 0 = flush, 1 = rst; asserted during CALC step 10 (cycle T+11).
    task automatic run_abort(input string nm, input bit use_rst);
        @(posedge clk); #1;
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd5000;
        divisor    = 32'd7;
        @(posedge clk);
        repeat (11) @(negedge clk);
        #1;
        div_start = 1'b0;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_done_after"}, done, 1'b0);
        chk({nm, "_info_after"}, info_hilo_ex, 68'd0);
        $display("abort %s during step 10: busy=%0b info=%h", nm, busy, info_hilo_ex);
        repeat (40) begin
            @(negedge clk);
            chk({nm, "_no_done"}, done, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_info", info_hilo_ex, 68'd0);

        chk("model_divu_100_7", model_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_div_m7_2", model_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_div_min_m1", model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});

        run_div("divu_100_7",     1'b0, 32'd100,       32'd7,         32'd14,         32'd2,          33, 1'b0);
        run_div("div_m7_2",       1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF,  33, 1'b0);
        run_div("div_min_m1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          33, 1'b0);
        run_div("divu_min_max",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000,  33, 1'b0);
        run_div("divu_by_zero",   1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234,  1,  1'b0);
        run_div("div_by_zero",    1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9,  1,  1'b0);
        run_div("div_7_m2",       1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          33, 1'b0);
        run_div("divu_max_16",    1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'd15,         33, 1'b0);

        run_abort("flush", 1'b0);
        run_div("after_flush",    1'b0, 32'd1000,      32'd3,         32'd333,       32'd1,          33, 1'b0);
        run_abort("rst", 1'b1);
        run_div("after_rst",      1'b0, 32'd1000,      32'd3,         32'd333,       32'd1,          33, 1'b0);

        run_div("busy_restart",   1'b0, 32'd50000,     32'd123,       32'd406,       32'd62,         33, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
